lcd_fb_arbiter: RTL and testbench

LCD_FB_ARBITER -- requirements
Module: lcd_fb_arbiter

---
 rtl/lcd_fb_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_lcd_fb_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_fb_arbiter.sv
// Framebuffer arbiter: LCD scan reads have priority over buffered game-logic pixel writes.
// Optional macro LCD_FB_ARB_STARVE_GUARD_EN forces a write grant after 8 consecutive reads.
module lcd_fb_arbiter #(
  parameter int LCD_W      = 132,
  parameter int LCD_H      = 162,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic [7:0]  rd_x,
  input  logic [7:0]  rd_y,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  input  logic        wr_req,
  input  logic [7:0]  wr_x,
  input  logic [7:0]  wr_y,
  input  logic [15:0] wr_data,
  output logic        wr_ready,
  output logic [14:0] ram_addr,
  output logic        ram_we,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  output logic        busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [8:0] W9 = 9'(LCD_W);
  localparam logic [8:0] H9 = 9'(LCD_H);

  typedef enum logic [1:0] {IDLE, READ, READ_WAIT, WRITE} state_t;

  function automatic logic [14:0] pix_addr(input logic [7:0] x, input logic [7:0] y);
    return 15'(y) * 15'(LCD_W) + 15'(x);
  endfunction

  function automatic logic in_range(input logic [7:0] x, input logic [7:0] y);
    return ({1'b0, x} < W9) && ({1'b0, y} < H9);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  state_t         state_q, state_d;
  logic           pend_q, pend_d, pend_oor_q, pend_oor_d, cur_oor_q, cur_oor_d;
  logic [14:0]    pend_addr_q, pend_addr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [14:0]    ram_addr_q, ram_addr_d;
  logic [15:0]    ram_wdata_q, ram_wdata_d, rd_data_q, rd_data_d;
  logic           ram_we_q, ram_we_d, rd_valid_q, rd_valid_d;
  logic           busy_q, busy_d, wr_ready_q, wr_ready_d;
  logic           push, pop, force_wr, rd_in;
  logic [14:0]    rd_addr;
  logic [14:0]    fifo_addr_q [FIFO_DEPTH];
  logic [15:0]    fifo_data_q [FIFO_DEPTH];

  assign rd_addr = pix_addr(rd_x, rd_y);
  assign rd_in   = in_range(rd_x, rd_y);

`ifdef LCD_FB_ARB_STARVE_GUARD_EN
  logic [3:0] guard_q, guard_d;
  assign force_wr = guard_q[3] && (count_q != '0);

  // Counts read grants made while writes are waiting; saturates at 8.
  always_comb begin
    guard_d = guard_q;
    if (state_d == WRITE || count_q == '0) guard_d = '0;
    else if (state_d == READ && state_q != READ && !guard_q[3]) guard_d = guard_q + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) guard_q <= '0;
    else     guard_q <= guard_d;
  end
`else
  assign force_wr = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    pend_oor_d  = pend_oor_q;
    cur_oor_d   = cur_oor_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    pop         = 1'b0;
    // Out-of-range writes are acknowledged but never enter the FIFO.
    push        = wr_req && wr_ready_q && in_range(wr_x, wr_y);
    case (state_q)
      IDLE: begin
        if (count_q != '0 && (force_wr || (!pend_q && !rd_req))) begin
          pop         = 1'b1;
          state_d     = WRITE;
          ram_we_d    = 1'b1;
          ram_addr_d  = fifo_addr_q[rd_ptr_q];
          ram_wdata_d = fifo_data_q[rd_ptr_q];
          if (rd_req && !pend_q) begin
            pend_d      = 1'b1;
            pend_addr_d = rd_addr;
            pend_oor_d  = !rd_in;
          end
        end else if (pend_q) begin
          state_d   = READ;
          pend_d    = 1'b0;
          cur_oor_d = pend_oor_q;
          if (!pend_oor_q) ram_addr_d = pend_addr_q;
        end else if (rd_req) begin
          state_d   = READ;
          cur_oor_d = !rd_in;
          if (rd_in) ram_addr_d = rd_addr;
        end
      end
      READ: state_d = READ_WAIT;
      READ_WAIT: begin
        state_d    = IDLE;
        rd_valid_d = 1'b1;
        rd_data_d  = cur_oor_q ? 16'h0000 : ram_rdata;
      end
      WRITE: begin
        if (pend_q) begin
          state_d   = READ;
          pend_d    = 1'b0;
          cur_oor_d = pend_oor_q;
          if (!pend_oor_q) ram_addr_d = pend_addr_q;
        end else begin
          state_d = IDLE;
          if (rd_req) begin
            pend_d      = 1'b1;
            pend_addr_d = rd_addr;
            pend_oor_d  = !rd_in;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    wr_ready_d = (count_d != CW'(FIFO_DEPTH));
    busy_d     = (state_d == READ) || (state_d == READ_WAIT) || pend_d || (count_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      wr_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      busy_q      <= busy_d;
      wr_ready_q  <= wr_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    pend_addr_q <= pend_addr_d;
    pend_oor_q  <= pend_oor_d;
    cur_oor_q   <= cur_oor_d;
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= pix_addr(wr_x, wr_y);
      fifo_data_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign wr_ready  = wr_ready_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_lcd_fb_arbiter.sv
// Scoreboard bench for lcd_fb_arbiter: reference framebuffer plus expected read/write queues.
module tb_lcd_fb_arbiter;
  localparam int LCD_W = 132;
  localparam int LCD_H = 162;
  localparam int FIFO_DEPTH = 4;

  logic clk, rst, rd_req, rd_valid, wr_req, wr_ready, ram_we, busy;
  logic [7:0] rd_x, rd_y, wr_x, wr_y;
  logic [15:0] rd_data, wr_data, ram_wdata, ram_rdata;
  logic [14:0] ram_addr;

  lcd_fb_arbiter #(.LCD_W(LCD_W), .LCD_H(LCD_H), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y),
    .rd_data(rd_data), .rd_valid(rd_valid), .wr_req(wr_req), .wr_x(wr_x),
    .wr_y(wr_y), .wr_data(wr_data), .wr_ready(wr_ready), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  typedef struct { logic [15:0] data; int lat; int issue; } rd_exp_t;
  typedef struct { logic [14:0] addr; logic [15:0] data; } wr_exp_t;

  rd_exp_t rdq[$];
  wr_exp_t wrq[$];
  int wx_log[$];
  int wy_log[$];
  logic [15:0] ram [32768];
  logic [15:0] model_mem [32768];
  int cyc = 0, checks = 0, errors = 0, rd_pulses = 0, wr_pulses = 0;
  rd_exp_t mon_re;
  wr_exp_t mon_we;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Framebuffer memory seen by the DUT: one-cycle registered read.
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: expected event did not occur as required", name);
  endtask

  function automatic logic [15:0] exp_rd(input int x, input int y);
    if (x < LCD_W && y < LCD_H) return model_mem[y * LCD_W + x];
    return 16'h0000;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid) begin
        rd_pulses++;
        if (rdq.size() == 0) fail("rd_unexpected");
        else begin
          mon_re = rdq.pop_front();
          chk("rd_data", rd_data, mon_re.data);
          if (mon_re.lat != 0) chk("rd_latency", cyc - mon_re.issue, mon_re.lat);
        end
      end
      if (ram_we) begin
        wr_pulses++;
        if (wrq.size() == 0) fail("ram_we_unexpected");
        else begin
          mon_we = wrq.pop_front();
          chk("ram_addr_wr", ram_addr, mon_we.addr);
          chk("ram_wdata", ram_wdata, mon_we.data);
        end
      end
    end
  end

  // Issue at a negedge; returns at the negedge showing rd_valid.
  task automatic do_read(input int x, input int y, input int lat, input bit ck_addr, input int exp_addr);
    rd_exp_t e;
    int n;
    rd_req = 1'b1; rd_x = 8'(x); rd_y = 8'(y);
    e.data = exp_rd(x, y); e.lat = lat; e.issue = cyc;
    rdq.push_back(e);
    @(negedge clk);
    rd_req = 1'b0;
    if (ck_addr) chk("ram_addr_rd", ram_addr, exp_addr);
    n = 0;
    while (!rd_valid && n < 20) begin @(negedge clk); n++; end
    if (!rd_valid) fail("rd_timeout");
  endtask

  task automatic do_write(input int x, input int y, input logic [15:0] d);
    wr_exp_t e;
    int n;
    wr_req = 1'b1; wr_x = 8'(x); wr_y = 8'(y); wr_data = d;
    n = 0;
    while (!wr_ready && n < 300) begin @(negedge clk); n++; end
    if (!wr_ready) fail("wr_timeout");
    else if (x < LCD_W && y < LCD_H) begin
      e.addr = 15'(y * LCD_W + x); e.data = d;
      wrq.push_back(e);
      model_mem[y * LCD_W + x] = d;
      wx_log.push_back(x); wy_log.push_back(y);
    end
    @(negedge clk);
    wr_req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((wrq.size() > 0 || rdq.size() > 0) && n < 200) begin @(negedge clk); n++; end
    if (wrq.size() > 0 || rdq.size() > 0) fail("drain_timeout");
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_ram_we"}, ram_we, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_ram_wdata"}, ram_wdata, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_wr_ready"}, wr_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int wp0, rp0;
    for (int i = 0; i < 32768; i++) begin
      ram[i] = 16'((i * 37 + 11) ^ (i >> 3));
      model_mem[i] = ram[i];
    end
    ram[0] = 16'hF800; model_mem[0] = 16'hF800;
    rst = 1'b1; rd_req = 0; rd_x = 0; rd_y = 0; wr_req = 0; wr_x = 0; wr_y = 0; wr_data = 0;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    do_read(0, 0, 3, 1'b1, 0);
    do_write(131, 161, 16'hFFE0);
    repeat (4) @(negedge clk);

    do_read(132, 0, 3, 1'b1, 21383);
    do_read(5, 162, 3, 1'b1, 21383);
    wp0 = wr_pulses;
    do_write(5, 200, 16'hABCD);
    repeat (5) @(negedge clk);
    chk("oor_write_no_we", wr_pulses - wp0, 0);

    // A read landing on the write cycle is served one cycle later.
    do_write(10, 110, 16'h1357);
    @(negedge clk);
    do_read(3, 4, 4, 1'b0, 0);
    drain();

    // Back-to-back reads hold the bus while five writes are pushed.
    wp0 = wr_pulses;
    fork
      begin
        for (int i = 0; i < 12; i++) do_read($urandom_range(0, LCD_W - 1), $urandom_range(0, 99), 3, 1'b0, 0);
`ifdef LCD_FB_ARB_STARVE_GUARD_EN
        chk("guard_write_granted", (wr_pulses - wp0) > 0, 1);
`else
        chk("reads_starve_writes", wr_pulses - wp0, 0);
`endif
      end
      begin
        for (int i = 0; i < 5; i++) begin
          do_write($urandom_range(0, LCD_W - 1), 100 + i, 16'($urandom));
          if (i == 3) begin
            chk("wr_ready_full", wr_ready, 0);
            chk("busy_full", busy, 1);
          end
        end
      end
    join
    drain();

    fork
      begin
        for (int i = 0; i < 20; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          if ($urandom_range(0, 9) == 0) do_read(LCD_W + $urandom_range(0, 100), $urandom_range(0, 255), 0, 1'b0, 0);
          else do_read($urandom_range(0, LCD_W - 1), $urandom_range(0, 99), 0, 1'b0, 0);
        end
      end
      begin
        for (int i = 0; i < 20; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          if ($urandom_range(0, 9) == 0) do_write($urandom_range(0, 255), LCD_H + $urandom_range(0, 90), 16'($urandom));
          else do_write($urandom_range(0, LCD_W - 1), $urandom_range(100, LCD_H - 1), 16'($urandom));
        end
      end
    join
    drain();

    for (int i = 0; i < 4; i++) do_read(wx_log[i], wy_log[i], 3, 1'b0, 0);
    do_read(131, 161, 3, 1'b1, 21383);
    drain();
    chk("rdq_empty", rdq.size(), 0);
    chk("wrq_empty", wrq.size(), 0);

    // Reset during a read with a write queued: neither may complete.
    rd_req = 1'b1; rd_x = 8'd1; rd_y = 8'd1;
    wr_req = 1'b1; wr_x = 8'd2; wr_y = 8'd120; wr_data = 16'h4242;
    @(posedge clk);
    #2;
    rst = 1'b1;
    rdq.delete(); wrq.delete();
    rp0 = rd_pulses; wp0 = wr_pulses;
    @(negedge clk);
    rd_req = 1'b0; wr_req = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_state("rst_mid");
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_abort_no_rd_valid", rd_pulses - rp0, 0);
    chk("rst_abort_no_ram_we", wr_pulses - wp0, 0);

    do_read(0, 0, 3, 1'b1, 0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
